// File: rtl/key_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pack_pkg
// Description : Shared types and constants for the memcache key packer.
//               This covers the block geometry, the state encoding and the
//               block-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pack_pkg;

   localparam int BLOCK_BYTES = 12;
   localparam int MAXKEY_DEF  = 250;

   // One hash input block: {k2, k1, k0}, byte lane 0 in bits [7:0]
   typedef logic [8*BLOCK_BYTES-1:0] block_t;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_SEND    = 2'd1,
      ST_DROP    = 2'd2
   } key_state_e;

   // Number of 12-byte blocks needed to hold len bytes
   function automatic logic [7:0] nblk_of(input logic [7:0] len);
      return 8'((int'(len) + BLOCK_BYTES - 1) / BLOCK_BYTES);
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : key_packer_if
// Description : Byte-stream input and block-stream output bundle of the key
//               packer. The slave modport is the packer's view. The master
//               modport is the view of the parser and hash pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_packer_if;

   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;

   logic [31:0] m_k0;
   logic [31:0] m_k1;
   logic [31:0] m_k2;
   logic [7:0]  m_key_length;
   logic        m_first;
   logic        m_last;
   logic        m_valid;
   logic        m_ready;

   modport master (
      output s_data, s_valid, s_last, m_ready,
      input  s_ready, m_k0, m_k1, m_k2, m_key_length, m_first, m_last, m_valid
   );

   modport slave (
      input  s_data, s_valid, s_last, m_ready,
      output s_ready, m_k0, m_k1, m_k2, m_key_length, m_first, m_last, m_valid
   );

endinterface
`default_nettype wire

// File: rtl/key_pack_buf.sv
`default_nettype none
// ============================================================================
// Module      : key_pack_buf
// Description : Key buffer of NBLK 96-bit blocks. It has a single byte-lane
//               write port and an asynchronous block read port. Writing lane
//               0 of a block zeroes lanes 1..11 of that block, so the tail of
//               a short final block never shows bytes from an earlier key.
// Revision    : 1.0 - initial release
// ============================================================================
module key_pack_buf
   import key_pack_pkg::*;
#(
   parameter int NBLK = 21
) (
   input  wire logic       CLK,
   input  wire logic       RST,
   input  wire logic       i_wr_en,
   input  wire logic [7:0] i_wr_blk,
   input  wire logic [7:0] i_wr_lane,
   input  wire logic [7:0] i_wr_byte,
   input  wire logic [7:0] i_rd_blk,
   output block_t          o_rd_data
);

   block_t w_rows [NBLK];

   generate
      for (genvar b = 0; b < NBLK; b++) begin : g_blk
         block_t r_row;

         // Lane write into this block; a lane-0 write also clears the other lanes
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               r_row <= '0;
            end else if (i_wr_en && (i_wr_blk == 8'(b))) begin
               for (int l = 0; l < BLOCK_BYTES; l++) begin
                  if (i_wr_lane == 8'(l)) begin
                     r_row[8*l +: 8] <= i_wr_byte;
                  end else if (i_wr_lane == 8'd0) begin
                     r_row[8*l +: 8] <= 8'd0;
                  end
               end
            end
         end

         assign w_rows[b] = r_row;
      end
   endgenerate

   // Asynchronous read by block index; an out-of-range index reads zero
   always_comb begin
      o_rd_data = '0;
      for (int i = 0; i < NBLK; i++) begin
         if (i_rd_blk == 8'(i)) begin
            o_rd_data = w_rows[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/key_packer.sv
`default_nettype none
// ============================================================================
// Module      : key_packer
// Description : Front end of the memcache key hashing path. It collects a key
//               byte stream, then replays the key as little-endian 12-byte
//               blocks with the total length, first/last flags and a
//               valid/ready handshake. Keys longer than MAXKEY are dropped,
//               and the drop is signalled by a one-cycle err_overflow pulse.
//               Optional macro KEY_PACK_DROP_CNT_EN adds a saturating 16-bit
//               drop_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module key_packer
   import key_pack_pkg::*;
#(
   parameter int MAXKEY = MAXKEY_DEF,
   parameter int NBLK   = 21
) (
   input  wire logic   CLK,
   input  wire logic   RST,
   key_packer_if.slave bus,
   output logic        err_overflow
`ifdef KEY_PACK_DROP_CNT_EN
   ,
   output logic [15:0] drop_cnt
`endif
);

   localparam logic [1:0] c_COLLECT = ST_COLLECT;
   localparam logic [1:0] c_SEND    = ST_SEND;
   localparam logic [1:0] c_DROP    = ST_DROP;
   localparam logic [7:0] c_MAXKEY  = 8'(MAXKEY);
   localparam logic [7:0] c_LN_LAST = 8'(BLOCK_BYTES - 1);

   logic [1:0] r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_ln;
   logic [7:0] r_blk;
   logic [7:0] r_len;
   logic [7:0] r_nblk;
   logic [7:0] r_idx;
   logic       r_err;

   logic       w_accept;
   logic       w_full;
   logic       w_wr_en;
   logic       w_take;
   logic       w_is_last;
   block_t     w_rd;

   assign bus.s_ready = (r_state != c_SEND);
   assign w_accept    = bus.s_valid & bus.s_ready;
   // The key already holds MAXKEY bytes, so the next byte makes it over-length
   assign w_full      = (r_cnt == c_MAXKEY);
   assign w_wr_en     = w_accept && (r_state == c_COLLECT) && !w_full;
   assign w_take      = bus.m_valid & bus.m_ready;
   assign w_is_last   = (r_idx == (r_nblk - 8'd1));

   key_pack_buf #(
      .NBLK (NBLK)
   ) u_buf (
      .CLK       (CLK),
      .RST       (RST),
      .i_wr_en   (w_wr_en),
      .i_wr_blk  (r_blk),
      .i_wr_lane (r_ln),
      .i_wr_byte (bus.s_data),
      .i_rd_blk  (r_idx),
      .o_rd_data (w_rd)
   );

   // Control FSM: collect bytes, replay blocks, or discard an over-length key
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= c_COLLECT;
         r_cnt   <= 8'd0;
         r_ln    <= 8'd0;
         r_blk   <= 8'd0;
         r_len   <= 8'd0;
         r_nblk  <= 8'd0;
         r_idx   <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            c_COLLECT: begin
               if (w_accept) begin
                  if (w_full) begin
                     r_cnt <= 8'd0;
                     r_ln  <= 8'd0;
                     r_blk <= 8'd0;
                     if (bus.s_last) begin
                        r_err <= 1'b1;
                     end else begin
                        r_state <= c_DROP;
                     end
                  end else if (bus.s_last) begin
                     r_len   <= r_cnt + 8'd1;
                     r_nblk  <= r_blk + 8'd1;
                     r_idx   <= 8'd0;
                     r_cnt   <= 8'd0;
                     r_ln    <= 8'd0;
                     r_blk   <= 8'd0;
                     r_state <= c_SEND;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                     if (r_ln == c_LN_LAST) begin
                        r_ln  <= 8'd0;
                        r_blk <= r_blk + 8'd1;
                     end else begin
                        r_ln <= r_ln + 8'd1;
                     end
                  end
               end
            end
            c_DROP: begin
               if (w_accept && bus.s_last) begin
                  r_err   <= 1'b1;
                  r_state <= c_COLLECT;
               end
            end
            c_SEND: begin
               if (w_take) begin
                  if (w_is_last) begin
                     r_idx   <= 8'd0;
                     r_state <= c_COLLECT;
                  end else begin
                     r_idx <= r_idx + 8'd1;
                  end
               end
            end
            default: begin
               r_state <= c_COLLECT;
            end
         endcase
      end
   end

   assign bus.m_valid      = (r_state == c_SEND);
   assign bus.m_first      = bus.m_valid & (r_idx == 8'd0);
   assign bus.m_last       = bus.m_valid & w_is_last;
   assign bus.m_key_length = r_len;
   assign bus.m_k0         = w_rd[31:0];
   assign bus.m_k1         = w_rd[63:32];
   assign bus.m_k2         = w_rd[95:64];
   assign err_overflow     = r_err;

`ifdef KEY_PACK_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   // Count discarded keys, holding at the top value instead of wrapping
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_drop_cnt <= 16'd0;
      end else if (r_err && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire
